// File: rtl/light_countdown_pkg.sv
// Shared definitions for the lamp-phase countdown display: phase codes,
// segment constants and the BCD segment table (active-low {dp,g..a}).
package light_countdown_pkg;

    localparam logic [2:0] PH_G = 3'b100;
    localparam logic [2:0] PH_Y = 3'b010;
    localparam logic [2:0] PH_R = 3'b001;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_TAB [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // Exactly one lamp lit is the only legal phase.
    function automatic logic ph_valid(input logic [2:0] ph);
        return (ph == PH_G) || (ph == PH_Y) || (ph == PH_R);
    endfunction

endpackage

// File: rtl/light_countdown_seg7_dec.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show blank.
module seg7_dec
    import light_countdown_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (bcd == 4'(i)) seg = SEG_TAB[i];
        end
    end

endmodule

// File: rtl/light_countdown.sv
// Seconds-remaining display for the traffic-light phases, with its own 1 s prescaler.
// Optional last-3-seconds blink is compiled in when LIGHT_CD_BLINK_EN is defined.
module light_countdown
    import light_countdown_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000,
    parameter int G_SEC   = 6,
    parameter int Y_SEC   = 2,
    parameter int R_SEC   = 9
) (
    input  logic       ck,
    input  logic       rs,
    input  logic       x,
    input  logic       v,
    input  logic       d,
    output logic [7:0] hex1,
    output logic [7:0] hex0,
    output logic       err
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    if (G_SEC < 1 || G_SEC > 99 || Y_SEC < 1 || Y_SEC > 99 ||
        R_SEC < 1 || R_SEC > 99 || CLK_DIV < 2) begin : g_bad_param
        $error("light_countdown: phase lengths must be 1..99 and CLK_DIV >= 2");
    end

    logic [2:0]    ph, ph_q;
    logic          valid, chg, tick;
    logic [6:0]    cnt, load_val;
    logic [PW-1:0] pre;
    logic          bad_q;
    logic [3:0]    tens, ones;
    logic [7:0]    seg_t, seg_o, nxt1, nxt0;

    assign ph    = {x, v, d};
    assign valid = ph_valid(ph);
    assign chg   = (ph != ph_q);
    assign tick  = (pre == PRE_MAX) && !chg;

    always_comb begin
        case (ph)
            PH_G:    load_val = 7'(G_SEC);
            PH_Y:    load_val = 7'(Y_SEC);
            default: load_val = 7'(R_SEC);
        endcase
    end

    // A load discards a coincident tick, so the new phase always gets a full first second.
    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            ph_q  <= 3'b000;
            cnt   <= 7'd0;
            pre   <= '0;
            bad_q <= 1'b0;
        end else begin
            ph_q <= ph;
            if (!valid) begin
                cnt   <= 7'd0;
                pre   <= '0;
                bad_q <= 1'b1;
            end else if (chg) begin
                cnt   <= load_val;
                pre   <= '0;
                bad_q <= 1'b0;
            end else begin
                bad_q <= 1'b0;
                pre   <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
                if (tick && cnt != 7'd0) cnt <= cnt - 7'd1;
            end
        end
    end

    assign tens = 4'(cnt / 7'd10);
    assign ones = 4'(cnt % 7'd10);

    seg7_dec u_dec_tens (.bcd(tens), .seg(seg_t));
    seg7_dec u_dec_ones (.bcd(ones), .seg(seg_o));

    always_comb begin
        nxt1 = (tens == 4'd0) ? SEG_BLANK : seg_t;
        nxt0 = seg_o;
`ifdef LIGHT_CD_BLINK_EN
        if (cnt >= 7'd1 && cnt <= 7'd3 && pre >= PW'(CLK_DIV / 2)) begin
            nxt1 = SEG_BLANK;
            nxt0 = SEG_BLANK;
        end
`endif
        if (bad_q) begin
            nxt1 = SEG_DASH;
            nxt0 = SEG_DASH;
        end
    end

    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            hex1 <= SEG_BLANK;
            hex0 <= SEG_BLANK;
            err  <= 1'b0;
        end else begin
            hex1 <= nxt1;
            hex0 <= nxt0;
            err  <= bad_q;
        end
    end

endmodule

// File: tb/tb_light_countdown.sv
// Directed bench for light_countdown: a CLK_DIV=4 instance with R=9 and a twin with R=12.
module tb_light_countdown;

    logic       ck = 1'b0;
    logic       rs = 1'b1;
    logic       x = 1'b1, v = 1'b0, d = 1'b0;
    logic [7:0] hex1, hex0, hex1_b, hex0_b;
    logic       err, err_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 ck = ~ck;

    light_countdown #(.CLK_DIV(4), .G_SEC(6), .Y_SEC(2), .R_SEC(9)) dut (
        .ck(ck), .rs(rs), .x(x), .v(v), .d(d),
        .hex1(hex1), .hex0(hex0), .err(err)
    );

    light_countdown #(.CLK_DIV(4), .G_SEC(6), .Y_SEC(2), .R_SEC(12)) dut12 (
        .ck(ck), .rs(rs), .x(x), .v(v), .d(d),
        .hex1(hex1_b), .hex0(hex0_b), .err(err_b)
    );

    task automatic step(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic test_reset;
        step(1);
        checks++; if (hex1 !== 8'hFF) begin errors++; $display("FAIL rst_hex1 got %h exp ff", hex1); end
        checks++; if (hex0 !== 8'hFF) begin errors++; $display("FAIL rst_hex0 got %h exp ff", hex0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        rs = 1'b0;
        step(2);
        checks++; if (hex0 !== 8'h82) begin errors++; $display("FAIL green_load got %h exp 82", hex0); end
        checks++; if (hex1 !== 8'hFF) begin errors++; $display("FAIL green_tens got %h exp ff", hex1); end
        step(3);
        checks++; if (hex0 !== 8'h82) begin errors++; $display("FAIL green_hold got %h exp 82", hex0); end
        step(1);
        checks++; if (hex0 !== 8'h92) begin errors++; $display("FAIL green_dec got %h exp 92", hex0); end
    endtask

    task automatic test_phase_change;
        step(1);  // prescaler now at 2
        x = 1'b0; v = 1'b1;
        step(2);
        checks++; if (hex0 !== 8'hA4) begin errors++; $display("FAIL yel_load got %h exp a4", hex0); end
        step(2);
        checks++; if (hex0 !== 8'hA4) begin errors++; $display("FAIL yel_early got %h exp a4", hex0); end
        step(2);
        checks++; if (hex0 !== 8'hF9) begin errors++; $display("FAIL yel_dec got %h exp f9", hex0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL yel_err got %b exp 0", err); end
    endtask

    task automatic test_countdown_red;
        int val;
        v = 1'b0; d = 1'b1;
        step(2);
        checks++; if (hex0 !== 8'h90) begin errors++; $display("FAIL red_load got %h exp 90", hex0); end
        for (int i = 1; i <= 12; i++) begin
            step(4);
            val = (9 - i < 0) ? 0 : 9 - i;
            checks++;
            if (hex0 !== seg_tab[val]) begin
                errors++; $display("FAIL red_tick%0d got %h exp %h", i, hex0, seg_tab[val]);
            end
            checks++; if (hex1 !== 8'hFF) begin errors++; $display("FAIL red_tens%0d got %h exp ff", i, hex1); end
        end
    endtask

    task automatic test_error;
        x = 1'b1;  // x and d together
        step(2);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err2_flag got %b exp 1", err); end
        checks++; if (hex1 !== 8'hBF) begin errors++; $display("FAIL err2_hex1 got %h exp bf", hex1); end
        checks++; if (hex0 !== 8'hBF) begin errors++; $display("FAIL err2_hex0 got %h exp bf", hex0); end
        x = 1'b0; d = 1'b0;  // no lamp at all
        step(2);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err0_flag got %b exp 1", err); end
        checks++; if (hex0 !== 8'hBF) begin errors++; $display("FAIL err0_hex0 got %h exp bf", hex0); end
        d = 1'b1;
        step(2);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
        checks++; if (hex0 !== 8'h90) begin errors++; $display("FAIL err_reload got %h exp 90", hex0); end
        checks++; if (hex1_b !== 8'hF9) begin errors++; $display("FAIL r12_tens got %h exp f9", hex1_b); end
        checks++; if (hex0_b !== 8'hA4) begin errors++; $display("FAIL r12_ones got %h exp a4", hex0_b); end
    endtask

    task automatic test_async_reset;
        step(20);
        checks++; if (hex0 !== 8'h99) begin errors++; $display("FAIL mid_cnt4 got %h exp 99", hex0); end
        rs = 1'b1;
        #1;
        checks++; if (hex1 !== 8'hFF) begin errors++; $display("FAIL async_hex1 got %h exp ff", hex1); end
        checks++; if (hex0 !== 8'hFF) begin errors++; $display("FAIL async_hex0 got %h exp ff", hex0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_err got %b exp 0", err); end
        step(1);
        rs = 1'b0;
        step(2);
        checks++; if (hex0 !== 8'h90) begin errors++; $display("FAIL rst_reload got %h exp 90", hex0); end
        checks++; if (hex0_b !== 8'hA4) begin errors++; $display("FAIL rst_reload12 got %h exp a4", hex0_b); end
    endtask

    task automatic test_last_seconds;
        logic [7:0] exp_hi;
`ifdef LIGHT_CD_BLINK_EN
        exp_hi = 8'hFF;
`else
        exp_hi = 8'hB0;
`endif
        step(37);
        checks++; if (hex0_b !== 8'hB0) begin errors++; $display("FAIL cnt3_low got %h exp b0", hex0_b); end
        step(1);
        checks++; if (hex0_b !== exp_hi) begin errors++; $display("FAIL cnt3_high got %h exp %h", hex0_b, exp_hi); end
        checks++; if (hex1_b !== 8'hFF) begin errors++; $display("FAIL cnt3_tens got %h exp ff", hex1_b); end
        step(2);
        checks++; if (hex0_b !== 8'hA4) begin errors++; $display("FAIL cnt2 got %h exp a4", hex0_b); end
    endtask

    initial begin
        test_reset();
        test_phase_change();
        test_countdown_red();
        test_error();
        test_async_reset();
        test_last_seconds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
